alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each requester owns a one-deep response register; results are captured one cycle after accept.
module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           req1_ready,
    output logic           rsp0_valid,
    output logic [DW-1:0]  rsp0_res,
    output logic           rsp0_zero,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    output logic [DW-1:0]  rsp1_res,
    output logic           rsp1_zero,
    input  logic           rsp1_ready,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    input  logic [DW-1:0]  alu_res,
    input  logic           alu_zero,
    output logic           busy
);

    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_res_q, rsp0_res_d;
    logic [DW-1:0] rsp1_res_q, rsp1_res_d;
    logic          rsp0_zero_q, rsp0_zero_d;
    logic          rsp1_zero_q, rsp1_zero_d;
    logic          rr_q, rr_d;
    logic          elig0, elig1, grant0, grant1;

    always_comb begin
        // A slot that is draining this cycle can accept a new result at the same edge.
        elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
        elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
        grant0 = rst_n & elig0 & (~elig1 | ~rr_q);
        grant1 = rst_n & elig1 & (~elig0 | rr_q);

        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        if (grant0) begin
            alu_op  = req0_op;
            alu_in1 = req0_a;
            alu_in2 = req0_b;
        end else if (grant1) begin
            alu_op  = req1_op;
            alu_in1 = req1_a;
            alu_in2 = req1_b;
        end

        rsp0_valid_d = rsp0_valid_q;
        rsp0_res_d   = rsp0_res_q;
        rsp0_zero_d  = rsp0_zero_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_res_d   = alu_res;
            rsp0_zero_d  = alu_zero;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        rsp1_valid_d = rsp1_valid_q;
        rsp1_res_d   = rsp1_res_q;
        rsp1_zero_d  = rsp1_zero_q;
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_res_d   = alu_res;
            rsp1_zero_d  = alu_zero;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end

        rr_d = rr_q;
        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_res_q   <= '0;
            rsp1_res_q   <= '0;
            rsp0_zero_q  <= 1'b0;
            rsp1_zero_q  <= 1'b0;
            rr_q         <= 1'b0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_res_q   <= rsp0_res_d;
            rsp1_res_q   <= rsp1_res_d;
            rsp0_zero_q  <= rsp0_zero_d;
            rsp1_zero_q  <= rsp1_zero_d;
            rr_q         <= rr_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_res   = rsp0_res_q;
    assign rsp1_res   = rsp1_res_q;
    assign rsp0_zero  = rsp0_zero_q;
    assign rsp1_zero  = rsp1_zero_q;
    assign busy       = rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU, expected results queued on
// accept and checked by a monitor whenever a response is consumed.
module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_AND = 4'h0;
    localparam logic [OPW-1:0] OP_OR  = 4'h1;
    localparam logic [OPW-1:0] OP_ADD = 4'h2;
    localparam logic [OPW-1:0] OP_SUB = 4'h6;
    localparam logic [OPW-1:0] OP_BNE = 4'h7;

    logic           clk;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic [OPW-1:0] req0_op, req1_op;
    logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           rsp0_valid, rsp1_valid;
    logic [DW-1:0]  rsp0_res, rsp1_res;
    logic           rsp0_zero, rsp1_zero;
    logic           rsp0_ready, rsp1_ready;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_in1, alu_in2;
    logic [DW-1:0]  alu_res;
    logic           alu_zero;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_res(rsp0_res), .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_res(rsp1_res), .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_res(alu_res), .alu_zero(alu_zero), .busy(busy)
    );

    // Shared ALU model; BNE reports Zero inverted.
    always_comb begin
        case (alu_op)
            OP_AND:  alu_res = alu_in1 & alu_in2;
            OP_OR:   alu_res = alu_in1 | alu_in2;
            OP_ADD:  alu_res = alu_in1 + alu_in2;
            OP_SUB:  alu_res = alu_in1 - alu_in2;
            OP_BNE:  alu_res = alu_in1 - alu_in2;
            default: alu_res = '0;
        endcase
        alu_zero = (alu_op == OP_BNE) ? (alu_res != '0) : (alu_res == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every consumed response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
                else chk("rsp0_result", {rsp0_zero, rsp0_res}, q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
                else chk("rsp1_result", {rsp1_zero, rsp1_res}, q1.pop_front());
            end
        end
    end

    task automatic cyc(
        input logic v0, input logic [OPW-1:0] o0, input logic [DW-1:0] a0, b0, e0r, input logic e0z,
        input logic v1, input logic [OPW-1:0] o1, input logic [DW-1:0] a1, b1, e1r, input logic e1z,
        input logic r0, r1, g0, g1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        #3;
        chk("req0_ready", {32'd0, req0_ready}, {32'd0, g0});
        chk("req1_ready", {32'd0, req1_ready}, {32'd0, g1});
        if (g0) begin
            chk("alu_bus_g0", {1'b0, alu_op, alu_in1 ^ alu_in2}, {1'b0, o0, a0 ^ b0});
            chk("alu_in1_g0", {1'b0, alu_in1}, {1'b0, a0});
            q0.push_back({e0z, e0r});
        end else if (g1) begin
            chk("alu_bus_g1", {1'b0, alu_op, alu_in1 ^ alu_in2}, {1'b0, o1, a1 ^ b1});
            chk("alu_in1_g1", {1'b0, alu_in1}, {1'b0, a1});
            q1.push_back({e1z, e1r});
        end else begin
            chk("alu_idle", {1'b0, alu_op, alu_in1 | alu_in2}, '0);
        end
    endtask

    task automatic idle(input logic r0, r1);
        cyc(0, '0, '0, '0, '0, 0, 0, '0, '0, '0, '0, 0, r0, r1, 0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1; rsp1_ready = 1;
        #1 rst_n = 1'b0;
        req0_valid = 1; req1_valid = 1;
        #2;
        chk("reset_outputs", {rsp0_zero, rsp0_res ^ rsp1_res, rsp1_zero},
            '0);
        chk("reset_flags", {29'd0, rsp0_valid, rsp1_valid, busy, req0_ready | req1_ready}, '0);
        @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, req0_ready, req1_ready}, '0);
        req0_valid = 0; req1_valid = 0;
        #6 rst_n = 1'b1;

        // tie after reset: 0 wins, then alternate
        cyc(1, OP_ADD, 1, 2, 3, 0,  1, OP_SUB, 3, 3, 0, 1,  1, 1, 1, 0);
        cyc(1, OP_ADD, 1, 2, 3, 0,  1, OP_SUB, 3, 3, 0, 1,  1, 1, 0, 1);
        chk("tie_rsp0_valid", {32'd0, rsp0_valid}, 1);
        cyc(1, OP_ADD, 1, 2, 3, 0,  1, OP_SUB, 3, 3, 0, 1,  1, 1, 1, 0);
        chk("tie_rsp1", {rsp1_zero, rsp1_res}, {1'b1, 32'd0});
        cyc(1, OP_ADD, 1, 2, 3, 0,  1, OP_SUB, 3, 3, 0, 1,  1, 1, 0, 1);
        idle(1, 1);
        idle(1, 1);
        chk("idle_busy", {32'd0, busy}, 0);

        // single request
        cyc(1, OP_ADD, 5, 7, 12, 0,  0, '0, '0, '0, '0, 0,  1, 1, 1, 0);
        chk("single_no_early_rsp", {32'd0, rsp0_valid}, 0);
        idle(1, 1);
        chk("single_rsp0", {rsp0_valid, rsp0_zero, rsp0_res[30:0]}, {1'b1, 1'b0, 31'd12});
        chk("single_busy", {32'd0, busy}, 1);

        // lone requester granted even though rr points at 1
        cyc(1, OP_ADD, 0, 0, 0, 1,  0, '0, '0, '0, '0, 0,  1, 1, 1, 0);

        // backpressure on slot 0
        cyc(1, OP_OR, 1, 2, 3, 0,  1, OP_AND, 32'hC, 32'hA, 32'h8, 0,  0, 1, 0, 1);
        chk("bp_rsp0_hold", {rsp0_zero, rsp0_res}, {1'b1, 32'd0});
        cyc(1, OP_OR, 1, 2, 3, 0,  0, '0, '0, '0, '0, 0,  0, 1, 0, 0);
        chk("bp_rsp0_stable", {rsp0_valid, rsp0_res}, {1'b1, 32'd0});
        chk("bp_rsp1", {rsp1_valid, rsp1_res}, {1'b1, 32'h8});

        // drain and reload in the same cycle
        cyc(1, OP_OR, 32'hF0, 32'h0F, 32'hFF, 0,  0, '0, '0, '0, '0, 0,  1, 1, 1, 0);
        idle(1, 1);
        chk("reload_rsp0", {rsp0_valid, rsp0_res}, {1'b1, 32'hFF});

        // BNE: zero flag captured exactly as the ALU delivers it
        cyc(1, OP_BNE, 4, 4, 0, 0,  0, '0, '0, '0, '0, 0,  1, 1, 1, 0);
        idle(1, 1);
        chk("bne_zero", {rsp0_valid, rsp0_zero}, {31'd0, 2'b10});

        // idle for 10 cycles; rr must still point at 1 afterwards
        for (int i = 0; i < 10; i++) idle(1, 1);
        chk("idle_busy_end", {32'd0, busy}, 0);
        cyc(1, OP_ADD, 10, 20, 30, 0,  1, OP_ADD, 1, 1, 2, 0,  1, 1, 0, 1);
        cyc(1, OP_ADD, 10, 20, 30, 0,  1, OP_ADD, 1, 1, 2, 0,  1, 1, 1, 0);

        // reset asserted after req1 is granted but before the edge
        @(posedge clk);
        #1;
        req0_valid = 0; req1_valid = 1; req1_op = OP_ADD; req1_a = 9; req1_b = 9;
        rsp0_ready = 1; rsp1_ready = 1;
        #3;
        chk("rst_pre_grant", {32'd0, req1_ready}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {30'd0, req1_ready, rsp1_valid, busy}, '0);
        q0.delete();
        q1.delete();
        req1_valid = 0;
        #1 rst_n = 1'b1;
        idle(1, 1);
        chk("rst_no_result", {31'd0, rsp1_valid, busy}, '0);
        cyc(1, OP_SUB, 8, 3, 5, 0,  1, OP_ADD, 2, 2, 4, 0,  1, 1, 1, 0);
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);
        chk("queues_drained", {31'd0, q0.size() == 0, q1.size() == 0}, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
